// File: rtl/lsu_pkg.sv
// Shared encodings and load-tag layout for the core-side data-port initiator.
package lsu_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NONE  = 2'b00,
      MEM_OP_LOAD  = 2'b01,
      MEM_OP_STORE = 2'b10
   } mem_op_e;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] size;
      logic       uns;
      logic [1:0] off;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/lsu_tag_fifo.sv
// Small synchronous FIFO holding load tags for issued-but-unreturned loads.
module lsu_tag_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 10,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      empty    = (cnt_q == '0);
      dout     = mem_q[rd_ptr_q];
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      count = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the core side of the data port: issues requests under
// the ready handshake, tracks outstanding loads and formats returned load data.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [1:0]        mem_op,
   output logic [1:0]        mem_size,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [4:0]        wb_rd,
   output logic              misalign,
   output logic              spurious,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int OW    = CNT_W + 1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              store_q, store_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [4:0]        rd_q, rd_d;
   logic              misalign_q, misalign_d;
   logic              wb_valid_q, wb_valid_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic              spurious_q, spurious_d;

   logic              hold, push, pop, accept, bad_req;
   logic [OW-1:0]     occ;
   logic [TAG_W-1:0]  fifo_dout;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   tag_t              head, new_tag;
   logic [31:0]       shifted, load_fmt;

   lsu_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (TAG_W)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .din   (new_tag),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      hold    = (state_q == HOLD);
      pop     = mem_rvalid & ~fifo_empty;
      push    = hold & mem_ready & ~store_q & ~fifo_full;
      new_tag = '{rd: rd_q, size: size_q, uns: uns_q, off: addr_q[1:0]};
      head    = tag_t'(fifo_dout);

      // Occupancy after this edge, counting the held load that is about to push,
      // so a newly accepted load can never find the queue full when it completes.
      occ       = OW'(fifo_count) + OW'(hold & ~store_q) - OW'(pop);
      req_ready = reset & (~hold | mem_ready)
                  & ~(~req_store & (occ >= OW'(MAX_OUTSTANDING)));
      accept    = req_valid & req_ready;
      bad_req   = (req_size == 2'b11)
                  | ((req_size == SIZE_H) & req_addr[0])
                  | ((req_size == SIZE_W) & (req_addr[1:0] != 2'b00));

      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rd_d    = rd_q;
      if (hold & mem_ready) begin
         state_d = IDLE;
      end
      if (accept & ~bad_req) begin
         state_d = HOLD;
         addr_d  = req_addr;
         store_d = req_store;
         size_d  = req_size;
         uns_d   = req_unsigned;
         rd_d    = req_rd;
         we_d    = '0;
         wdata_d = req_wdata;
         if (req_store) begin
            case (req_size)
               SIZE_B: begin
                  we_d    = 4'b0001 << req_addr[1:0];
                  wdata_d = {4{req_wdata[7:0]}};
               end
               SIZE_H: begin
                  we_d    = 4'b0011 << req_addr[1:0];
                  wdata_d = {2{req_wdata[15:0]}};
               end
               default: we_d = 4'b1111;
            endcase
         end
      end
      misalign_d = accept & bad_req;

      shifted = mem_rdata >> {head.off, 3'b000};
      case (head.size)
         SIZE_B:  load_fmt = {{24{~head.uns & shifted[7]}}, shifted[7:0]};
         SIZE_H:  load_fmt = {{16{~head.uns & shifted[15]}}, shifted[15:0]};
         default: load_fmt = shifted;
      endcase
      wb_valid_d = pop;
      wb_data_d  = pop ? load_fmt : wb_data_q;
      wb_rd_d    = pop ? head.rd : wb_rd_q;
      spurious_d = spurious_q | (mem_rvalid & fifo_empty);

      mem_en    = hold;
      mem_we    = hold ? we_q : '0;
      mem_addr  = hold ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      mem_wdata = hold ? wdata_q : '0;
      mem_op    = hold ? (store_q ? MEM_OP_STORE : MEM_OP_LOAD) : MEM_OP_NONE;
      mem_size  = hold ? size_q : '0;
      wb_valid  = wb_valid_q;
      wb_data   = wb_data_q;
      wb_rd     = wb_rd_q;
      misalign  = misalign_q;
      spurious  = spurious_q;
      busy      = hold | ~fifo_empty;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= '0;
         wdata_q    <= '0;
         store_q    <= 1'b0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         rd_q       <= '0;
         misalign_q <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         store_q    <= store_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         rd_q       <= rd_d;
         misalign_q <= misalign_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         spurious_q <= spurious_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scenario bench for lsu_mem_initiator: expected writebacks are queued when a
// response is driven and matched against wb_* by a monitor.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_op, mem_size;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        misalign, spurious, busy;

   int checks     = 0;
   int failures   = 0;
   int handshakes = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   lsu_mem_initiator #(
      .MAX_OUTSTANDING (2),
      .ADDR_W          (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_op       (mem_op),
      .mem_size     (mem_size),
      .mem_ready    (mem_ready),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .misalign     (misalign),
      .spurious     (spurious),
      .busy         (busy)
   );

   // Monitor samples one time unit before each rising edge.
   always @(negedge clk) begin
      #4;
      if (reset && mem_en && mem_ready) handshakes++;
      if (wb_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            e = sb.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data) begin
               failures++;
               $display("FAIL wb_result got rd=%0d data=%h, required rd=%0d data=%h",
                        wb_rd, wb_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic set_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      req_valid    = 1'b1;
      req_store    = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      req_rd       = rd;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_op, mem_size, wb_valid,
           wb_data, wb_rd, misalign, spurious, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got ready=%b en=%b op=%b busy=%b spur=%b, required all 0",
                  req_ready, mem_en, mem_op, busy, spurious);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got %b required 1", req_ready);
      end
   endtask

   task automatic test_store_byte();
      @(negedge clk);
      mem_ready = 1'b1;
      set_req(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h1234_56AB, 5'd0);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL sb_ready got %b required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({mem_en, mem_we, mem_wdata, mem_addr, mem_op, mem_size} !==
          {1'b1, 4'b1000, 32'hABAB_ABAB, 32'h8000_0000, 2'b10, 2'b00}) begin
         failures++;
         $display("FAIL sb_issue got en=%b we=%b wd=%h a=%h op=%b sz=%b, required en=1 we=1000 wd=ababab ab a=80000000 op=10 sz=00",
                  mem_en, mem_we, mem_wdata, mem_addr, mem_op, mem_size);
      end
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL sb_done got en=%b busy=%b required 0 0", mem_en, busy);
      end
   endtask

   task automatic test_load_half(input logic uns, input logic [31:0] exp_data);
      @(negedge clk);
      mem_ready = 1'b1;
      set_req(1'b0, 2'b01, uns, 32'h8000_0002, 32'h0, 5'd7);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({mem_en, mem_op, mem_we, mem_addr, mem_size} !== {1'b1, 2'b01, 4'b0000, 32'h8000_0000, 2'b01}) begin
         failures++;
         $display("FAIL lh_issue got en=%b op=%b we=%b a=%h sz=%b, required 1 01 0000 80000000 01",
                  mem_en, mem_op, mem_we, mem_addr, mem_size);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || mem_en !== 1'b0) begin
         failures++;
         $display("FAIL lh_outstanding got busy=%b en=%b required 1 0", busy, mem_en);
      end
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8001_0000;
      sb.push_back('{rd: 5'd7, data: exp_data});
      @(negedge clk);
      mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL lh_drain got busy=%b required 0", busy);
      end
   endtask

   task automatic test_stall_store();
      int h0;
      h0 = handshakes;
      @(negedge clk);
      mem_ready = 1'b0;
      set_req(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 5'd0);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_accept got %b required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({mem_en, mem_we, mem_addr, mem_wdata, mem_op, req_ready} !==
             {1'b1, 4'b1111, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL stall_hold[%0d] got en=%b we=%b a=%h wd=%h op=%b rdy=%b, required 1 1111 80000010 deadbeef 10 0",
                     i, mem_en, mem_we, mem_addr, mem_wdata, mem_op, req_ready);
         end
      end
      @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0) begin
         failures++;
         $display("FAIL stall_release got en=%b required 0", mem_en);
      end
      @(negedge clk);
      checks++;
      if (handshakes - h0 !== 1) begin
         failures++;
         $display("FAIL stall_single_issue got %0d handshakes required 1", handshakes - h0);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      mem_ready = 1'b1;
      set_req(1'b0, 2'b10, 1'b0, 32'h8000_0100, 32'h0, 5'd1);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready1 got %b required 1", req_ready);
      end
      @(negedge clk);
      set_req(1'b0, 2'b10, 1'b0, 32'h8000_0104, 32'h0, 5'd2);
      #1;
      checks++;
      if (req_ready !== 1'b1 || mem_addr !== 32'h8000_0100) begin
         failures++;
         $display("FAIL b2b_ready2 got rdy=%b a=%h required 1 80000100", req_ready, mem_addr);
      end
      @(negedge clk);
      set_req(1'b0, 2'b10, 1'b0, 32'h8000_0108, 32'h0, 5'd3);
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stall_hold got %b required 0", req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_stall_full got rdy=%b busy=%b required 0 1", req_ready, busy);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111_1111;
      sb.push_back('{rd: 5'd1, data: 32'h1111_1111});
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_release got %b required 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      mem_rdata = 32'h2222_2222;
      sb.push_back('{rd: 5'd2, data: 32'h2222_2222});
      checks++;
      if (mem_addr !== 32'h8000_0108 || mem_op !== 2'b01) begin
         failures++;
         $display("FAIL b2b_third_issue got a=%h op=%b required 80000108 01", mem_addr, mem_op);
      end
      @(negedge clk);
      mem_rdata = 32'h3333_3333;
      sb.push_back('{rd: 5'd3, data: 32'h3333_3333});
      @(negedge clk);
      mem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain got busy=%b pending=%0d required 0 0", busy, sb.size());
      end
   endtask

   task automatic test_misalign();
      logic        st_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] ad_t [3] = '{32'h8000_0001, 32'h8000_0005, 32'h8000_0000};
      int h0;
      for (int i = 0; i < 3; i++) begin
         h0 = handshakes;
         @(negedge clk);
         mem_ready = 1'b1;
         set_req(st_t[i], sz_t[i], 1'b0, ad_t[i], 32'hCAFE_F00D, 5'd4);
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mis_consume[%0d] got %b required 1", i, req_ready);
         end
         @(negedge clk);
         req_valid = 1'b0;
         checks++;
         if ({misalign, mem_en, busy} !== 3'b100) begin
            failures++;
            $display("FAIL mis_pulse[%0d] got mis=%b en=%b busy=%b required 1 0 0", i, misalign, mem_en, busy);
         end
         @(negedge clk);
         checks++;
         if ({misalign, mem_en, busy} !== 3'b000 || handshakes != h0) begin
            failures++;
            $display("FAIL mis_after[%0d] got mis=%b en=%b busy=%b hs=%0d required 0 0 0 0",
                     i, misalign, mem_en, busy, handshakes - h0);
         end
      end
   endtask

   task automatic test_spurious_reset();
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (spurious !== 1'b1) begin
         failures++;
         $display("FAIL spur_set got %b required 1", spurious);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (spurious !== 1'b1) begin
         failures++;
         $display("FAIL spur_sticky got %b required 1", spurious);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      set_req(1'b0, 2'b10, 1'b0, 32'h8000_0200, 32'h0, 5'd9);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_hold got en=%b busy=%b required 1 1", mem_en, busy);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_op, mem_size, wb_valid,
           wb_data, wb_rd, misalign, spurious, busy} !== '0) begin
         failures++;
         $display("FAIL rst_mid_hold got rdy=%b en=%b op=%b busy=%b spur=%b, required all 0",
                  req_ready, mem_en, mem_op, busy, spurious);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_en, busy, spurious} !== 3'b000) begin
         failures++;
         $display("FAIL rst_after got en=%b busy=%b spur=%b required 0 0 0", mem_en, busy, spurious);
      end
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BAD_0BAD;
      @(negedge clk);
      mem_rvalid = 1'b0;
      checks++;
      if (spurious !== 1'b1) begin
         failures++;
         $display("FAIL spur_late got %b required 1", spurious);
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_half(1'b0, 32'hFFFF_8001);
      test_load_half(1'b1, 32'h0000_8001);
      test_stall_store();
      test_back_to_back();
      test_misalign();
      test_spurious_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got %0d pending writebacks required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator on the core side of the data port (port B) of the memory-mapped IO subsystem.
- Takes execute-stage load/store requests and drives enB/weB/addrB/dinB/memOpIn/memSizeIn under the ready handshake.
- Tracks outstanding loads in a small tag queue and aligns and sign/zero-extends returned doutB data for writeback.
- Detects misaligned accesses and spurious read responses.

Parameters:
- MAX_OUTSTANDING, 2, maximum loads issued but not yet returned (tag queue depth, power of 2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  access accepted this cycle when high with req_valid.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load zero-extends (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination register.
- mem_en  out  1  to enB.
- mem_we  out  4  to weB; byte lane enables.
- mem_addr  out  ADDR_W  to addrB; word-aligned (low 2 bits forced 0).
- mem_wdata  out  32  to dinB.
- mem_op  out  2  to memOpIn: 00 none, 01 load, 10 store.
- mem_size  out  2  to memSizeIn; copy of req_size.
- mem_ready  in  1  from ready.
- mem_rvalid  in  1  from readValidB.
- mem_rdata  in  32  from doutB.
- wb_valid  out  1  one-cycle pulse with formatted load result.
- wb_data  out  32  formatted load data.
- wb_rd  out  5  destination register for wb_data.
- misalign  out  1  one-cycle pulse: rejected misaligned or illegal-size request.
- spurious  out  1  sticky: mem_rvalid seen with tag queue empty; cleared only by reset.
- busy  out  1  request held or loads outstanding.

Behaviour:
- Reset (reset low, async): state IDLE, queue empty, every output 0 except req_ready = 0 while reset is low.
- FSM IDLE / HOLD.
  - IDLE: mem_en = 0, mem_op = 00.
  - HOLD: request registers driven, mem_en = 1.
- Acceptance:
  - req_ready = (IDLE or (HOLD and mem_ready)) and not (load and queue full).
  - Accept → registers load and state = HOLD next cycle (latency 1).
  - In HOLD with mem_ready = 0, all mem_* outputs are held stable.
  - In HOLD with mem_ready = 1, the request completes. Next state is HOLD if a new request is accepted the same cycle, else IDLE.
- Misalignment: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - The request is consumed (req_ready high) and misalign pulses the next cycle.
  - No memory request is issued; no queue push.
- Store lanes, with off = addr[1:0]:
  - byte: mem_we = 0001 << off, mem_wdata = {4{wdata[7:0]}}.
  - half: mem_we = 0011 << off, mem_wdata = {2{wdata[15:0]}}.
  - word: mem_we = 1111, mem_wdata = wdata.
  - Loads: mem_we = 0000.
- Tag queue:
  - Entry = {rd, size, unsigned, off}.
  - Push when a load completes its handshake in HOLD; pop on mem_rvalid.
  - Push and pop in the same cycle are both allowed; count unchanged.
  - Full blocks new loads only; stores still issue.
- Response:
  - Head entry selects the data: shifted = mem_rdata >> (8*off); byte/half extended per size and unsigned.
  - wb_valid/wb_data/wb_rd are registered: one cycle after mem_rvalid.
  - Responses return in order.
- mem_rvalid with empty queue: no pop, no wb_valid, spurious set.
- busy = HOLD or queue non-empty.
- Reset mid-transaction discards held requests and outstanding tags; late mem_rvalid after reset flags spurious.

Decomposition:
- Shared package lsu_pkg holds:
  - mem_op encodings: MEM_OP_NONE, MEM_OP_LOAD, MEM_OP_STORE.
  - mem_size encodings: SIZE_B, SIZE_H, SIZE_W.
  - Load-tag entry layout width constant.
- One sub-module: lsu_tag_fifo, a synchronous FIFO of depth MAX_OUTSTANDING with async active-low reset, count, full/empty.
- Lane steering and extension stay inline.

Test Plan:
- Store byte, addr 0x8000_0003, wdata 0x1234_56AB, mem_ready = 1.
  - Next cycle: mem_en = 1, mem_we = 1000, mem_wdata = 0xABAB_ABAB, mem_addr = 0x8000_0000, mem_op = 10, mem_size = 00.
- Signed load half, addr 0x8000_0002, rd = 7.
  - Memory returns 0x8001_0000 two cycles later.
  - wb_data = 0xFFFF_8001 and wb_rd = 7 one cycle after rvalid. With req_unsigned = 1: 0x0000_8001.
- mem_ready held low 3 cycles during a word store.
  - mem_* outputs stable; req_ready = 0; single completion when ready rises; no duplicate issue.
- Three back-to-back loads (rd 1, 2, 3) with MAX_OUTSTANDING = 2 and responses delayed.
  - Third load stalled (req_ready = 0) until the first rvalid.
  - wb_rd sequence is 1, 2, 3.
- Word load at addr 0x8000_0001.
  - misalign pulses one cycle; mem_en never asserts; queue count stays 0.
- mem_rvalid with no outstanding load, then reset low mid-HOLD.
  - spurious = 1 until reset; after reset all outputs 0, busy = 0.
